conv_weights_bank: RTL

Multi-channel, double-buffered coefficient store for the convolution datapath. A serial word stream loads a K×K kernel plus bias into a shadow bank for one selected channel. A `swap` strobe commits every fully loaded shadow bank to the active bank, so new coefficients can be streamed in while the convolution engine keeps using the current set.

---
 rtl/conv_weights_bank.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/conv_weights_bank.sv
// Double-buffered multi-channel kernel/bias store: a serial session fills one channel's
// shadow bank; swap moves every complete shadow bank into the active bank.
module conv_weights_bank #(
  parameter int DW  = 16,
  parameter int K   = 3,
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    wr_start,
  input  logic [CW-1:0]           wr_ch,
  input  logic                    wr_en,
  input  logic [DW-1:0]           wr_data,
  input  logic                    swap,
  output logic [NCH*K*K*DW-1:0]   weights_o,
  output logic [NCH*DW-1:0]       bias_o,
  output logic [NCH-1:0]          weights_ready,
  output logic [NCH-1:0]          shadow_full,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int NW = K * K;
  localparam int PW = $clog2(NW + 1);
  localparam logic [PW-1:0] BIAS_PTR = PW'(NW);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic             wr_hit;
  logic [CW-1:0]    wr_sel;
  logic [PW-1:0]    wr_idx;
  logic             start_ok;
  logic             complete;
  logic             done_d, err_d;

  logic [DW-1:0]    shadow_q [NCH][NW+1];
  logic [DW-1:0]    act_w_q  [NCH][NW];
  logic [DW-1:0]    act_b_q  [NCH];
  logic [NCH-1:0]   full_q, ready_q;
  logic             done_q, err_q;

  function automatic logic ch_valid(input logic [CW-1:0] c);
    return 32'(c) < 32'(NCH);
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ch_d     = ch_q;
    wr_hit   = 1'b0;
    wr_sel   = ch_q;
    wr_idx   = ptr_q;
    start_ok = 1'b0;
    complete = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (wr_start) begin
      // A start always wins over an in-flight session; the old session is dropped.
      if (ch_valid(wr_ch)) begin
        start_ok = 1'b1;
        state_d  = LOAD;
        ch_d     = wr_ch;
        ptr_d    = '0;
        if (wr_en) begin
          wr_hit = 1'b1;
          wr_sel = wr_ch;
          wr_idx = '0;
          ptr_d  = PW'(1);
        end
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
        ptr_d   = '0;
      end
    end else if (wr_en) begin
      if (state_q == LOAD) begin
        wr_hit = 1'b1;
        if (ptr_q == BIAS_PTR) begin
          complete = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
          ptr_d    = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
      full_q  <= '0;
      ready_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        act_b_q[c] <= '0;
        for (int i = 0; i <= NW; i++) shadow_q[c][i] <= '0;
        for (int i = 0; i < NW; i++) act_w_q[c][i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (wr_hit) shadow_q[wr_sel][wr_idx] <= wr_data;
      for (int c = 0; c < NCH; c++) begin
        if (swap && full_q[c]) begin
          for (int i = 0; i < NW; i++) act_w_q[c][i] <= shadow_q[c][i];
          act_b_q[c] <= shadow_q[c][NW];
          ready_q[c] <= 1'b1;
          full_q[c]  <= 1'b0;
        end
        if (start_ok && (wr_ch == CW'(c))) full_q[c] <= 1'b0;
        // A bias write coinciding with swap only marks the bank full; it commits next swap.
        if (complete && (ch_q == CW'(c))) full_q[c] <= 1'b1;
      end
    end
  end

  always_comb begin
    weights_o = '0;
    bias_o    = '0;
    for (int c = 0; c < NCH; c++) begin
      bias_o[c*DW +: DW] = act_b_q[c];
      for (int i = 0; i < NW; i++) weights_o[(c*NW+i)*DW +: DW] = act_w_q[c][i];
    end
  end

  assign weights_ready = ready_q;
  assign shadow_full   = full_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule
